// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI receive path: command opcodes, decoder
// states and the window clamp helper.
package lcd_spi_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_CASET,
      ST_RASET,
      ST_RAMWR,
      ST_IGNORE
   } dec_state_e;

   typedef struct packed {
      logic [15:0] s;
      logic [15:0] e;
   } span_t;

   // Both ends are limited to the panel edge, and the start never passes the end.
   function automatic span_t clamp_span(input logic [15:0] s, input logic [15:0] e,
                                        input logic [15:0] max_v);
      span_t r;
      r.e = (e > max_v) ? max_v : e;
      r.s = (s > max_v) ? max_v : s;
      if (r.s > r.e) r.s = r.e;
      return r;
   endfunction

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronises the link, detects sclk
// rises and assembles MSB-first bytes tagged with the dc level of the last bit.
module lcd_spi_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       lcd_spi_sclk,
   input  logic       lcd_spi_mosi,
   input  logic       lcd_spi_cs,
   input  logic       lcd_dc,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc
);

   // Each stage holds {sclk, mosi, cs, dc}; cs idles high.
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [3:0]                  link_s;
   logic                        sclk_s, mosi_s, cs_s, dc_s;
   logic                        sclk_prev;
   logic                        sclk_rise;
   logic [7:0]                  shift_q;
   logic [2:0]                  bit_cnt;

   assign link_s    = sync_q[SYNC_STAGES-1];
   assign sclk_s    = link_s[3];
   assign mosi_s    = link_s[2];
   assign cs_s      = link_s[1];
   assign dc_s      = link_s[0];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign byte_data = shift_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q    <= {SYNC_STAGES{4'b0010}};
         sclk_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], {lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc}};
         sclk_prev <= sclk_s;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shift_q    <= '0;
         bit_cnt    <= '0;
         byte_valid <= 1'b0;
         byte_dc    <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (cs_s) begin
            shift_q <= '0;
            bit_cnt <= '0;
         end else if (sclk_rise) begin
            shift_q <= {shift_q[6:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               byte_dc    <= dc_s;
            end
         end
      end
   end

endmodule

// File: rtl/lcd_spi_rx_decoder.sv
// ST7789-style command decoder: tracks the CASET/RASET window, walks the RAMWR
// cursor and emits addressed RGB565 pixels with an end-of-frame marker.
module lcd_spi_rx_decoder
   import lcd_spi_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH  = 32'd320,
   parameter int unsigned SCREEN_HEIGHT = 32'd240,
   parameter int          SYNC_STAGES   = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        lcd_spi_sclk,
   input  logic        lcd_spi_mosi,
   input  logic        lcd_spi_cs,
   input  logic        lcd_dc,
   output logic        cmd_valid_o,
   output logic [7:0]  cmd_byte_o,
   output logic        pixel_valid_o,
   output logic [15:0] pixel_data_o,
   output logic [15:0] pixel_x_o,
   output logic [15:0] pixel_y_o,
   output logic        frame_done_o
);

   localparam logic [15:0] X_MAX = 16'(SCREEN_WIDTH - 1);
   localparam logic [15:0] Y_MAX = 16'(SCREEN_HEIGHT - 1);

   logic        byte_valid, byte_dc;
   logic [7:0]  byte_data;
   logic        is_cmd, is_data;

   dec_state_e  state_q, state_d;
   logic [2:0]  param_idx;
   logic [23:0] param_q;
   logic        phase_q;
   logic [7:0]  hi_q;
   logic [15:0] xs_q, xe_q, ys_q, ye_q;
   logic [15:0] cur_x, cur_y;

   logic        ramwr_start, param_load, x_commit, y_commit, hi_load, pixel_fire;
   logic        at_xe, at_ye;
   span_t       x_span, y_span;

   lcd_spi_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_byte_rx (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .lcd_spi_sclk (lcd_spi_sclk),
      .lcd_spi_mosi (lcd_spi_mosi),
      .lcd_spi_cs   (lcd_spi_cs),
      .lcd_dc       (lcd_dc),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_dc      (byte_dc)
   );

   assign is_cmd  = byte_valid & ~byte_dc;
   assign is_data = byte_valid &  byte_dc;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= ST_CMD;
      else            state_q <= state_d;
   end

   // Any command byte re-dispatches, whatever state the decoder is in.
   always_comb begin
      state_d = state_q;
      if (is_cmd) begin
         unique case (byte_data)
            CMD_CASET: state_d = ST_CASET;
            CMD_RASET: state_d = ST_RASET;
            CMD_RAMWR: state_d = ST_RAMWR;
            default:   state_d = ST_IGNORE;
         endcase
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      ramwr_start = is_cmd && (byte_data == CMD_RAMWR);
      param_load  = 1'b0;
      x_commit    = 1'b0;
      y_commit    = 1'b0;
      hi_load     = 1'b0;
      pixel_fire  = 1'b0;
      if (is_data) begin
         unique case (state_q)
            ST_CASET, ST_RASET: begin
               if (!param_idx[2]) begin
                  param_load = 1'b1;
                  x_commit   = (state_q == ST_CASET) && (param_idx == 3'd3);
                  y_commit   = (state_q == ST_RASET) && (param_idx == 3'd3);
               end
            end
            ST_RAMWR: begin
               hi_load    = ~phase_q;
               pixel_fire =  phase_q;
            end
            default: ;
         endcase
      end
   end

   // The fourth parameter byte arrives live; the first three sit in param_q.
   assign x_span = clamp_span(param_q[23:8], {param_q[7:0], byte_data}, X_MAX);
   assign y_span = clamp_span(param_q[23:8], {param_q[7:0], byte_data}, Y_MAX);
   assign at_xe  = (cur_x == xe_q);
   assign at_ye  = (cur_y == ye_q);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cmd_valid_o   <= 1'b0;
         cmd_byte_o    <= '0;
         pixel_valid_o <= 1'b0;
         pixel_data_o  <= '0;
         pixel_x_o     <= '0;
         pixel_y_o     <= '0;
         frame_done_o  <= 1'b0;
         param_idx     <= '0;
         param_q       <= '0;
         phase_q       <= 1'b0;
         hi_q          <= '0;
         xs_q          <= '0;
         xe_q          <= X_MAX;
         ys_q          <= '0;
         ye_q          <= Y_MAX;
         cur_x         <= '0;
         cur_y         <= '0;
      end else begin
         cmd_valid_o   <= is_cmd;
         pixel_valid_o <= pixel_fire;
         frame_done_o  <= pixel_fire & at_xe & at_ye;
         if (is_cmd) cmd_byte_o <= byte_data;

         if (is_cmd)          param_idx <= '0;
         else if (param_load) param_idx <= param_idx + 3'd1;
         if (param_load) param_q <= {param_q[15:0], byte_data};
         if (x_commit) {xs_q, xe_q} <= x_span;
         if (y_commit) {ys_q, ye_q} <= y_span;

         if (is_cmd) begin
            phase_q <= 1'b0;
         end else if (hi_load) begin
            phase_q <= 1'b1;
            hi_q    <= byte_data;
         end else if (pixel_fire) begin
            phase_q <= 1'b0;
         end

         if (ramwr_start) begin
            cur_x <= xs_q;
            cur_y <= ys_q;
         end else if (pixel_fire) begin
            pixel_data_o <= {hi_q, byte_data};
            pixel_x_o    <= cur_x;
            pixel_y_o    <= cur_y;
            if (at_xe) begin
               cur_x <= xs_q;
               cur_y <= at_ye ? ys_q : cur_y + 16'd1;
            end else begin
               cur_x <= cur_x + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// Scoreboard bench for lcd_spi_rx_decoder: a window/linear-index reference model
// predicts commands and pixels; a monitor compares whenever the DUT pulses.
`timescale 1ns/1ps
module tb_lcd_spi_rx_decoder;

   localparam int W = 320;
   localparam int H = 240;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        lcd_spi_sclk = 1'b0;
   logic        lcd_spi_mosi = 1'b0;
   logic        lcd_spi_cs = 1'b1;
   logic        lcd_dc = 1'b0;
   logic        cmd_valid_o;
   logic [7:0]  cmd_byte_o;
   logic        pixel_valid_o;
   logic [15:0] pixel_data_o;
   logic [15:0] pixel_x_o;
   logic [15:0] pixel_y_o;
   logic        frame_done_o;

   lcd_spi_rx_decoder dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .lcd_spi_sclk  (lcd_spi_sclk),
      .lcd_spi_mosi  (lcd_spi_mosi),
      .lcd_spi_cs    (lcd_spi_cs),
      .lcd_dc        (lcd_dc),
      .cmd_valid_o   (cmd_valid_o),
      .cmd_byte_o    (cmd_byte_o),
      .pixel_valid_o (pixel_valid_o),
      .pixel_data_o  (pixel_data_o),
      .pixel_x_o     (pixel_x_o),
      .pixel_y_o     (pixel_y_o),
      .frame_done_o  (frame_done_o)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] d;
      bit          fd;
   } pix_t;

   logic [7:0] cmd_q[$];
   pix_t       pix_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int pix_seen = 0;
   int fd_seen  = 0;
   int cmd_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: window state plus a linear pixel index since the last RAMWR.
   int         m_state;  // 0 = no data accepted, 1 = CASET, 2 = RASET, 3 = RAMWR
   int         m_xs, m_xe, m_ys, m_ye, m_n;
   bit         m_have_hi;
   logic [7:0] m_hi;
   int         m_par[$];

   function automatic void model_reset();
      m_state = 0;
      m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1;
      m_n = 0; m_have_hi = 0; m_hi = '0;
      m_par.delete();
      cmd_q.delete();
      pix_q.delete();
   endfunction

   task automatic model_byte(input bit dc, input logic [7:0] b);
      if (!dc) begin
         cmd_q.push_back(b);
         m_par.delete();
         m_have_hi = 0;
         m_state = (b == 8'h2A) ? 1 : (b == 8'h2B) ? 2 : (b == 8'h2C) ? 3 : 0;
         if (b == 8'h2C) m_n = 0;
      end else if (m_state == 1 || m_state == 2) begin
         if (m_par.size() < 4) begin
            m_par.push_back(int'(b));
            if (m_par.size() == 4) begin
               int lim, s, e;
               lim = (m_state == 1) ? W - 1 : H - 1;
               s = m_par[0] * 256 + m_par[1];
               e = m_par[2] * 256 + m_par[3];
               if (e > lim) e = lim;
               if (s > lim) s = lim;
               if (s > e) s = e;
               if (m_state == 1) begin m_xs = s; m_xe = e; end
               else              begin m_ys = s; m_ye = e; end
            end
         end
      end else if (m_state == 3) begin
         if (!m_have_hi) begin
            m_hi = b;
            m_have_hi = 1;
         end else begin
            int w, h, k;
            pix_t p;
            w = m_xe - m_xs + 1;
            h = m_ye - m_ys + 1;
            k = m_n % (w * h);
            p.x = m_xs + k % w;
            p.y = m_ys + k / w;
            p.d = {m_hi, b};
            p.fd = (k == w * h - 1);
            pix_q.push_back(p);
            m_n++;
            m_have_hi = 0;
         end
      end
   endtask

   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (cmd_valid_o) begin
            cmd_seen++;
            if (cmd_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL cmd_unexpected: got cmd 0x%0h expected none", cmd_byte_o);
            end else begin
               check("cmd_byte", 32'(cmd_byte_o), 32'(cmd_q.pop_front()));
            end
         end
         if (pixel_valid_o) begin
            pix_seen++;
            if (frame_done_o) fd_seen++;
            if (pix_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL pix_unexpected: got pixel at (%0d,%0d) expected none", pixel_x_o, pixel_y_o);
            end else begin
               pix_t p;
               p = pix_q.pop_front();
               check("pix_x", 32'(pixel_x_o), p.x);
               check("pix_y", 32'(pixel_y_o), p.y);
               check("pix_data", 32'(pixel_data_o), 32'(p.d));
               check("frame_done", 32'(frame_done_o), 32'(p.fd));
            end
         end else if (frame_done_o) begin
            n_checks++; n_errors++;
            $display("FAIL frame_done_alone: got frame_done=1 without pixel_valid expected 0");
         end
      end
   end

   task automatic send_bits(input bit dc, input logic [7:0] b, input int nbits);
      lcd_spi_cs = 1'b0;
      for (int i = 7; i > 7 - nbits; i--) begin
         lcd_spi_sclk = 1'b0;
         lcd_spi_mosi = b[i];
         lcd_dc = dc;
         repeat (2) @(negedge sys_clk);
         lcd_spi_sclk = 1'b1;
         repeat (2) @(negedge sys_clk);
      end
      lcd_spi_sclk = 1'b0;
   endtask

   task automatic send_byte(input bit dc, input logic [7:0] b);
      model_byte(dc, b);
      send_bits(dc, b, 8);
   endtask

   task automatic send_win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
      send_byte(1'b0, cmd);
      send_byte(1'b1, s[15:8]);
      send_byte(1'b1, s[7:0]);
      send_byte(1'b1, e[15:8]);
      send_byte(1'b1, e[7:0]);
   endtask

   task automatic send_pixels(input int n, input bit fixed, input logic [15:0] d);
      logic [15:0] v;
      for (int i = 0; i < n; i++) begin
         v = fixed ? d : 16'($urandom);
         send_byte(1'b1, v[15:8]);
         send_byte(1'b1, v[7:0]);
      end
   endtask

   task automatic cs_idle();
      lcd_spi_sclk = 1'b0;
      repeat (2) @(negedge sys_clk);
      lcd_spi_cs = 1'b1;
      repeat (4) @(negedge sys_clk);
      lcd_spi_cs = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((cmd_q.size() != 0 || pix_q.size() != 0) && t < 200) begin
         @(negedge sys_clk);
         t++;
      end
      n_checks++;
      if (t >= 200) begin
         n_errors++;
         $display("FAIL %s_drain: got %0d cmds and %0d pixels pending expected 0", name, cmd_q.size(), pix_q.size());
      end
      repeat (6) @(negedge sys_clk);
   endtask

   task automatic apply_reset();
      lcd_spi_sclk = 1'b0;
      lcd_spi_cs = 1'b1;
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("rst_cmd_valid", 32'(cmd_valid_o), 0);
      check("rst_cmd_byte", 32'(cmd_byte_o), 0);
      check("rst_pix_valid", 32'(pixel_valid_o), 0);
      check("rst_pix_data", 32'(pixel_data_o), 0);
      check("rst_pix_x", 32'(pixel_x_o), 0);
      check("rst_pix_y", 32'(pixel_y_o), 0);
      check("rst_frame_done", 32'(frame_done_o), 0);
      model_reset();
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
   endtask

   function automatic logic [15:0] rand_coord(input int max_v);
      if ($urandom_range(0, 4) == 0) return 16'($urandom);
      return 16'($urandom_range(0, max_v));
   endfunction

   initial begin
      #3ms;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, f0, c0;
      model_reset();
      apply_reset();

      // 4x2 window, two rows of pixels, frame end on (3,1).
      send_win(8'h2A, 16'd0, 16'd3);
      send_win(8'h2B, 16'd0, 16'd1);
      p0 = pix_seen; f0 = fd_seen;
      send_byte(1'b0, 8'h2C);
      send_pixels(8, 1'b0, 16'h0);
      drain("small_window");
      check("small_pix_count", pix_seen - p0, 8);
      check("small_frame_count", fd_seen - f0, 1);

      // Default columns on the last row: frame end at (319,239), then wrap.
      apply_reset();
      send_win(8'h2B, 16'h00EF, 16'hFFFF);
      p0 = pix_seen; f0 = fd_seen;
      send_byte(1'b0, 8'h2C);
      send_pixels(W + 1, 1'b1, 16'hF800);
      drain("last_row");
      check("row_pix_count", pix_seen - p0, W + 1);
      check("row_frame_count", fd_seen - f0, 1);
      check("row_wrap_x", 32'(pixel_x_o), 0);
      check("row_wrap_y", 32'(pixel_y_o), H - 1);

      // XE clamped to 319: 64-pixel rows, 65th lands at (256,1).
      apply_reset();
      send_win(8'h2A, 16'h0100, 16'h01FF);
      send_byte(1'b0, 8'h2C);
      send_pixels(65, 1'b0, 16'h0);
      drain("clamp_x");
      check("clamp_x_last_x", 32'(pixel_x_o), 256);
      check("clamp_x_last_y", 32'(pixel_y_o), 1);

      // Bottom-right 2x2 corner with both ends clamped.
      send_win(8'h2A, 16'h013E, 16'hFFFF);
      send_win(8'h2B, 16'h00EE, 16'h1234);
      f0 = fd_seen;
      send_byte(1'b0, 8'h2C);
      send_pixels(5, 1'b0, 16'h0);
      drain("corner");
      check("corner_frame_count", fd_seen - f0, 1);
      check("corner_wrap_x", 32'(pixel_x_o), 318);
      check("corner_wrap_y", 32'(pixel_y_o), 238);

      // XS > XE collapses XS onto XE.
      send_win(8'h2A, 16'd200, 16'd100);
      send_byte(1'b0, 8'h2C);
      send_pixels(3, 1'b0, 16'h0);
      drain("xs_gt_xe");

      // Partial byte aborted by cs, then RAMWR command.
      send_bits(1'b0, 8'hA5, 5);
      cs_idle();
      c0 = cmd_seen;
      send_byte(1'b0, 8'h2C);
      drain("cs_abort");
      check("cs_abort_cmd_count", cmd_seen - c0, 1);
      check("cs_abort_cmd_byte", 32'(cmd_byte_o), 32'h2C);

      // Dangling high byte dropped by an unknown command; IGNORE swallows data.
      p0 = pix_seen;
      send_byte(1'b0, 8'h2C);
      send_pixels(1, 1'b0, 16'h0);
      send_byte(1'b1, 8'h5A);
      send_byte(1'b0, 8'h00);
      send_pixels(2, 1'b0, 16'h0);
      drain("ignore");
      check("ignore_pix_count", pix_seen - p0, 1);

      // Reset mid-RAMWR and mid-byte restores the default window and cursor.
      send_win(8'h2A, 16'd10, 16'd20);
      send_win(8'h2B, 16'd5, 16'd9);
      send_byte(1'b0, 8'h2C);
      send_pixels(1, 1'b0, 16'h0);
      send_byte(1'b1, 8'h77);
      drain("pre_reset");
      send_bits(1'b1, 8'h3C, 4);
      apply_reset();
      send_byte(1'b0, 8'h2C);
      send_pixels(2, 1'b0, 16'h0);
      drain("post_reset");
      check("post_reset_x", 32'(pixel_x_o), 1);
      check("post_reset_y", 32'(pixel_y_o), 0);

      // Randomised command mix against the model.
      for (int it = 0; it < 40; it++) begin
         int r, n;
         logic [7:0] c;
         r = $urandom_range(0, 9);
         case (r)
            0, 1: begin
               send_win(8'h2A, rand_coord(400), rand_coord(400));
               if ($urandom_range(0, 3) == 0) send_byte(1'b1, 8'($urandom));
            end
            2, 3: begin
               send_win(8'h2B, rand_coord(300), rand_coord(300));
               if ($urandom_range(0, 3) == 0) send_byte(1'b1, 8'($urandom));
            end
            4, 5, 6, 7: begin
               send_byte(1'b0, 8'h2C);
               n = $urandom_range(0, 14);
               for (int k = 0; k < n; k++) send_byte(1'b1, 8'($urandom));
            end
            8: begin
               c = 8'($urandom);
               if (c >= 8'h2A && c <= 8'h2C) c = 8'h29;
               send_byte(1'b0, c);
               n = $urandom_range(0, 3);
               for (int k = 0; k < n; k++) send_byte(1'b1, 8'($urandom));
            end
            default: begin
               send_bits(1'($urandom), 8'($urandom), $urandom_range(1, 7));
               cs_idle();
            end
         endcase
         if ($urandom_range(0, 4) == 0) cs_idle();
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
